// File: rtl/apb_master_interface.sv
// ---------------------------------------------------------------------------
// apb_master_interface
//
// APB3 initiator. Turns a valid/ready command port into single APB transfers
// (SETUP then ACCESS), waits for pready and hands back read data and an error
// flag as a one-cycle response pulse. A wait-state timeout aborts a transfer
// whose slave never raises pready, so a hung slave cannot stall the command
// source.
//
// Ports:
//   apb_pclk_i     clock, everything on the rising edge
//   apb_preset_i   synchronous active-high reset
//   cmd_valid_i    command request
//   cmd_ready_o    high while idle; command taken when valid && ready
//   cmd_write_i    1 = write, 0 = read
//   cmd_addr_i     transfer address
//   cmd_wdata_i    write data
//   rsp_valid_o    one-cycle response pulse, no backpressure
//   rsp_rdata_o    read data (0 for writes and timeouts)
//   rsp_err_o      pslverr or timeout, qualified by rsp_valid_o
//   busy_o         high during SETUP and ACCESS
//   apb_paddr_o, apb_psel_o, apb_penable_o, apb_pwrite_o, apb_pwdata_o
//                  APB request side, all registered
//   apb_pready_i, apb_prdata_i, apb_pslverr_i
//                  APB completion side, only looked at in ACCESS
// ---------------------------------------------------------------------------
module apb_master_interface #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  apb_pclk_i,
    input  logic                  apb_preset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] apb_paddr_o,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [DATA_WIDTH-1:0] apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic [DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                  apb_pslverr_i
);

    // The counter only needs to reach TIMEOUT_CYCLES; a disabled timeout
    // still gets a 1-bit counter so the logic stays well formed.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  pwrite_q,    pwrite_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  rspValid_q,  rspValid_d;
    logic                  rspErr_q,    rspErr_d;
    logic [DATA_WIDTH-1:0] rspRdata_q,  rspRdata_d;
    logic [CNT_W-1:0]      waitCnt_q,   waitCnt_d;

    // State and every APB/response output live in this one register bank,
    // so all outputs except cmd_ready_o/busy_o come straight from flops.
    always_ff @(posedge apb_pclk_i) begin
        if (apb_preset_i) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
            waitCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspRdata_q <= rspRdata_d;
            waitCnt_q  <= waitCnt_d;
        end
    end

    // Next-state logic. Everything holds by default except the response
    // pulse, which is only raised on the edge that ends a transfer.
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        rspValid_d = 1'b0;
        rspErr_d   = rspErr_q;
        rspRdata_d = rspRdata_q;
        waitCnt_d  = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    paddr_d   = cmd_addr_i;
                    pwdata_d  = cmd_wdata_i;
                    pwrite_d  = cmd_write_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                waitCnt_d = '0;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // pready is checked first so it wins over a timeout that
                // would fire on the same edge.
                if (apb_pready_i) begin
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rspValid_d = 1'b1;
                    rspErr_d   = apb_pslverr_i;
                    rspRdata_d = pwrite_q ? '0 : apb_prdata_i;
                    state_d    = IDLE;
                end else begin
                    waitCnt_d = (waitCnt_q == CNT_MAX) ? waitCnt_q : waitCnt_q + 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (waitCnt_d == CNT_LIMIT)) begin
                        psel_d     = 1'b0;
                        penable_d  = 1'b0;
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspRdata_d = '0;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = rspValid_q;
    assign rsp_rdata_o   = rspRdata_q;
    assign rsp_err_o     = rspErr_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_master_interface.sv
// ---------------------------------------------------------------------------
// tb_apb_master_interface
//
// Drives commands into apb_master_interface (TIMEOUT_CYCLES = 4) while a
// behavioural APB slave answers with a planned number of wait states. Each
// issued command pushes its expected response (data, error, arrival cycle)
// into a scoreboard queue; an independent monitor pops and compares whenever
// rsp_valid_o rises and also checks the busy/ready/psel/penable phase every
// cycle against the transfer windows the scoreboard implies.
// ---------------------------------------------------------------------------
module tb_apb_master_interface;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acceptCyc;
        int          rspCyc;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [31:0] cmdWdata;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        busy;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   tbHold;

    expEntry_t expQ[$];
    txn_t      planQ[$];

    txn_t      slvCur;
    bit        slvHaveCur = 1'b0;
    int        slvIdx = 0;
    expEntry_t monEntry;

    apb_master_interface #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .apb_pclk_i   (clk),
        .apb_preset_i (rst),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .cmd_write_i  (cmdWrite),
        .cmd_addr_i   (cmdAddr),
        .cmd_wdata_i  (cmdWdata),
        .rsp_valid_o  (rspValid),
        .rsp_rdata_o  (rspRdata),
        .rsp_err_o    (rspErr),
        .busy_o       (busy),
        .apb_paddr_o  (paddr),
        .apb_psel_o   (psel),
        .apb_penable_o(penable),
        .apb_pwrite_o (pwrite),
        .apb_pwdata_o (pwdata),
        .apb_pready_i (pready),
        .apb_prdata_i (prdata),
        .apb_pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a slave that answers after 'waits' stalled ACCESS
    // cycles completes at ACCESS cycle waits+1; the master gives up after
    // TIMEOUT stalled cycles. The response lands the cycle after the end.
    function automatic expEntry_t predict(input txn_t t, input int acc);
        expEntry_t e;
        e.acceptCyc = acc;
        if (t.waits >= TIMEOUT) begin
            e.err    = 1'b1;
            e.rdata  = 32'h0;
            e.rspCyc = acc + 3 + (TIMEOUT - 1);
        end else begin
            e.err    = t.slverr;
            e.rdata  = t.write ? 32'h0 : t.rdata;
            e.rspCyc = acc + 3 + t.waits;
        end
        return e;
    endfunction

    // Called right after a rising edge. Leaves cmdValid high on return so
    // consecutive calls issue back-to-back commands.
    task automatic applyStimulus(input txn_t t);
        bit accepted;
        accepted = 1'b0;
        cmdValid = 1'b1;
        cmdWrite = t.write;
        cmdAddr  = t.addr;
        cmdWdata = t.wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmdReady === 1'b1) begin
                expQ.push_back(predict(t, cyc));
                planQ.push_back(t);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("accept_timeout", cmdReady, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        cmdValid = 1'b0;
        cmdAddr  = $urandom;
        cmdWdata = $urandom;
        cmdWrite = 1'($urandom);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mkTxn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input logic se, input int ws);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.rdata = rd; t.slverr = se; t.waits = ws;
        return t;
    endfunction

    // Behavioural slave: drives completion signals on the falling edge for
    // the cycle that follows, and garbage whenever it is not completing, so
    // the master must ignore pready/prdata/pslverr outside a valid ACCESS.
    always @(negedge clk) begin
        if (psel === 1'b1 && penable === 1'b0) begin
            if (planQ.size() == 0) begin
                checkOutput("slave_unplanned_setup", psel, 0);
                slvHaveCur = 1'b0;
            end else begin
                slvCur     = planQ.pop_front();
                slvHaveCur = 1'b1;
                slvIdx     = 0;
            end
        end
        if (psel === 1'b1 && slvHaveCur && !tbHold) begin
            checkOutput("paddr_stable", paddr, slvCur.addr);
            checkOutput("pwdata_stable", pwdata, slvCur.wdata);
            checkOutput("pwrite_stable", pwrite, slvCur.write);
        end
        if (psel === 1'b1 && penable === 1'b1 && slvHaveCur) begin
            if (slvIdx == slvCur.waits) begin
                pready  = 1'b1;
                prdata  = slvCur.rdata;
                pslverr = slvCur.slverr;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
            slvIdx++;
        end else begin
            pready  = 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
    end

    // Monitor: phase checks every cycle, response checks on each pulse.
    always @(negedge clk) begin
        if (!tbHold) begin
            if (expQ.size() > 0 && cyc > expQ[0].acceptCyc && cyc < expQ[0].rspCyc) begin
                checkOutput("busy_active", busy, 1);
                checkOutput("cmd_ready_active", cmdReady, 0);
                checkOutput("psel_active", psel, 1);
                checkOutput("penable_phase", penable, 32'(cyc >= expQ[0].acceptCyc + 2));
            end else begin
                checkOutput("busy_idle", busy, 0);
                checkOutput("cmd_ready_idle", cmdReady, 1);
                checkOutput("psel_idle", psel, 0);
                checkOutput("penable_idle", penable, 0);
            end
            if (rspValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("rsp_unexpected", rspValid, 0);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("rsp_rdata", rspRdata, monEntry.rdata);
                    checkOutput("rsp_err", rspErr, monEntry.err);
                    checkOutput("rsp_cycle", cyc, monEntry.rspCyc);
                end
            end else if (expQ.size() > 0 && cyc >= expQ[0].rspCyc) begin
                checkOutput("rsp_missing", rspValid, 1);
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t;
        tbHold   = 1'b1;
        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdWrite = 1'b0;
        cmdAddr  = 32'h0;
        cmdWdata = 32'h0;
        pready   = 1'b0;
        prdata   = 32'h0;
        pslverr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_psel", psel, 0);
        checkOutput("reset_penable", penable, 0);
        checkOutput("reset_pwrite", pwrite, 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        checkOutput("reset_rsp_valid", rspValid, 0);
        checkOutput("reset_rsp_err", rspErr, 0);
        checkOutput("reset_rsp_rdata", rspRdata, 0);
        checkOutput("reset_cmd_ready", cmdReady, 1);
        @(posedge clk);
        #1;
        tbHold = 1'b0;

        $display("[TB] directed: read, zero wait");
        applyStimulus(mkTxn(1'b0, 32'h1A10_0004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 0));
        waitIdle();

        $display("[TB] directed: write, three wait states");
        applyStimulus(mkTxn(1'b1, 32'h0000_0010, 32'h5A5A_0001, 32'hFFFF_FFFF, 1'b0, 3));
        waitIdle();

        $display("[TB] directed: read with pslverr");
        applyStimulus(mkTxn(1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b1, 1));
        waitIdle();

        $display("[TB] directed: timeout and pready on the last allowed cycle");
        applyStimulus(mkTxn(1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 1'b0, 100));
        waitIdle();
        applyStimulus(mkTxn(1'b0, 32'h0000_0304, 32'h0, 32'h3333_4444, 1'b1, 3));
        waitIdle();
        applyStimulus(mkTxn(1'b1, 32'h0000_0308, 32'h7777_8888, 32'h3333_4444, 1'b0, 3));
        waitIdle();

        $display("[TB] directed: four back-to-back commands");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkTxn(1'(i), 32'h0000_1000 + 32'(i * 4), $urandom, $urandom, 1'b0, 0));
        end
        waitIdle();

        $display("[TB] directed: reset during ACCESS");
        applyStimulus(mkTxn(1'b0, 32'h0000_2000, 32'h0, 32'hABCD_0000, 1'b0, 2));
        cmdValid = 1'b0;
        @(posedge clk);
        #1;
        tbHold = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        planQ.delete();
        slvHaveCur = 1'b0;
        tbHold = 1'b0;
        @(negedge clk);
        checkOutput("midreset_psel", psel, 0);
        checkOutput("midreset_penable", penable, 0);
        checkOutput("midreset_rsp_valid", rspValid, 0);
        checkOutput("midreset_cmd_ready", cmdReady, 1);
        @(posedge clk);
        #1;
        applyStimulus(mkTxn(1'b0, 32'h0000_2004, 32'h0, 32'h0BAD_C0DE, 1'b0, 0));
        waitIdle();

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            t = mkTxn(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 5));
            applyStimulus(t);
            if ($urandom_range(0, 2) != 0) begin
                cmdValid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
